// File: rtl/ex_operand_stage_if.sv
// Signal bundle between ID, the ID/EX operand stage, the forwarding sources and the ALU.
// The master side is the surrounding pipeline; the slave side is the operand stage.
interface ex_operand_stage_if #(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [XLEN-1:0]        id_pc;
   logic [XLEN-1:0]        id_imm;
   logic [XLEN-1:0]        id_rs1_data;
   logic [XLEN-1:0]        id_rs2_data;
   logic [4:0]             id_rs1;
   logic [4:0]             id_rs2;
   logic [4:0]             id_rd;
   logic                   id_use_rs1;
   logic                   id_use_rs2;
   logic                   id_src1_sel;
   logic                   id_src2_sel;
   logic [3:0]             id_alu_func;
   logic                   id_we;
   logic                   id_mem_read;
   logic                   flush;
   logic                   mem_valid;
   logic                   mem_we;
   logic [4:0]             mem_rd;
   logic [XLEN-1:0]        mem_result;
   logic                   wb_valid;
   logic                   wb_we;
   logic [4:0]             wb_rd;
   logic [XLEN-1:0]        wb_data;
   logic [XLEN-1:0]        alu_src1;
   logic [XLEN-1:0]        alu_src2;
   logic [3:0]             alu_func;
   logic                   ex_valid;
   logic                   ex_we;
   logic                   ex_mem_read;
   logic [4:0]             ex_rd;
   logic [XLEN-1:0]        ex_rs2_fwd;
   logic                   stall_ifid;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_src1_sel, id_src2_sel, id_alu_func, id_we,
             id_mem_read, flush, mem_valid, mem_we, mem_rd, mem_result,
             wb_valid, wb_we, wb_rd, wb_data,
      input  alu_src1, alu_src2, alu_func, ex_valid, ex_we, ex_mem_read, ex_rd,
             ex_rs2_fwd, stall_ifid, stall_cnt
   );

   modport slave (
      input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_src1_sel, id_src2_sel, id_alu_func, id_we,
             id_mem_read, flush, mem_valid, mem_we, mem_rd, mem_result,
             wb_valid, wb_we, wb_rd, wb_data,
      output alu_src1, alu_src2, alu_func, ex_valid, ex_we, ex_mem_read, ex_rd,
             ex_rs2_fwd, stall_ifid, stall_cnt
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers the decoded instruction, resolves both operands through
// MEM/WB forwarding, and inserts a one-cycle bubble on a load-use hazard.
module ex_operand_stage #(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 16
) (
   input logic               clk,
   input logic               rstn,
   ex_operand_stage_if.slave bus
);

   logic                   ex_valid_r;
   logic [XLEN-1:0]        ex_pc_r;
   logic [XLEN-1:0]        ex_imm_r;
   logic [XLEN-1:0]        ex_rs1_data_r;
   logic [XLEN-1:0]        ex_rs2_data_r;
   logic [4:0]             ex_rs1_r;
   logic [4:0]             ex_rs2_r;
   logic [4:0]             ex_rd_r;
   logic                   ex_src1_sel_r;
   logic                   ex_src2_sel_r;
   logic [3:0]             ex_alu_func_r;
   logic                   ex_we_r;
   logic                   ex_mem_read_r;
   logic [STALL_CNT_W-1:0] stall_cnt_r;

   logic [XLEN-1:0]        fwd_rs1_s;
   logic [XLEN-1:0]        fwd_rs2_s;
   logic [XLEN-1:0]        alu_src1_s;
   logic [XLEN-1:0]        alu_src2_s;
   logic                   ex_we_s;
   logic                   ex_mem_read_s;
   logic                   dep_s;
   logic                   stall_s;

   // MEM has priority over WB; x0 is hard-wired to zero whatever the register file says.
   function automatic logic [XLEN-1:0] fwd_operand(
      input logic [4:0]      r,
      input logic [XLEN-1:0] rf_data,
      input logic            mem_hit_en,
      input logic [4:0]      mem_rd,
      input logic [XLEN-1:0] mem_result,
      input logic            wb_hit_en,
      input logic [4:0]      wb_rd,
      input logic [XLEN-1:0] wb_data
   );
      logic [XLEN-1:0] val;
      if (r == 5'd0) begin
         val = {XLEN{1'b0}};
      end else if (mem_hit_en && (mem_rd == r)) begin
         val = mem_result;
      end else if (wb_hit_en && (wb_rd == r)) begin
         val = wb_data;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

   // Operand resolution and EX control qualification.
   always_comb begin
      fwd_rs1_s = fwd_operand(ex_rs1_r, ex_rs1_data_r,
                              bus.mem_valid & bus.mem_we, bus.mem_rd, bus.mem_result,
                              bus.wb_valid & bus.wb_we, bus.wb_rd, bus.wb_data);
      fwd_rs2_s = fwd_operand(ex_rs2_r, ex_rs2_data_r,
                              bus.mem_valid & bus.mem_we, bus.mem_rd, bus.mem_result,
                              bus.wb_valid & bus.wb_we, bus.wb_rd, bus.wb_data);
      if (ex_src1_sel_r) begin
         alu_src1_s = ex_pc_r;
      end else begin
         alu_src1_s = fwd_rs1_s;
      end
      if (ex_src2_sel_r) begin
         alu_src2_s = ex_imm_r;
      end else begin
         alu_src2_s = fwd_rs2_s;
      end
      ex_we_s       = ex_valid_r & ex_we_r;
      ex_mem_read_s = ex_valid_r & ex_mem_read_r;
   end

   // Load-use detection; a flush squashes the dependent instruction so no stall is needed.
   always_comb begin
      dep_s   = (bus.id_use_rs1 & (bus.id_rs1 == ex_rd_r)) |
                (bus.id_use_rs2 & (bus.id_rs2 == ex_rd_r));
      stall_s = ex_mem_read_s & (ex_rd_r != 5'd0) & bus.id_valid & ~bus.flush & dep_s;
   end

   // EX pipeline register: reset > flush > stall bubble > capture from ID.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ex_valid_r    <= 1'b0;
         ex_pc_r       <= {XLEN{1'b0}};
         ex_imm_r      <= {XLEN{1'b0}};
         ex_rs1_data_r <= {XLEN{1'b0}};
         ex_rs2_data_r <= {XLEN{1'b0}};
         ex_rs1_r      <= 5'd0;
         ex_rs2_r      <= 5'd0;
         ex_rd_r       <= 5'd0;
         ex_src1_sel_r <= 1'b0;
         ex_src2_sel_r <= 1'b0;
         ex_alu_func_r <= 4'd0;
         ex_we_r       <= 1'b0;
         ex_mem_read_r <= 1'b0;
      end else if (bus.flush || stall_s) begin
         ex_valid_r    <= 1'b0;
      end else begin
         ex_valid_r    <= bus.id_valid;
         ex_pc_r       <= bus.id_pc;
         ex_imm_r      <= bus.id_imm;
         ex_rs1_data_r <= bus.id_rs1_data;
         ex_rs2_data_r <= bus.id_rs2_data;
         ex_rs1_r      <= bus.id_rs1;
         ex_rs2_r      <= bus.id_rs2;
         ex_rd_r       <= bus.id_rd;
         ex_src1_sel_r <= bus.id_src1_sel;
         ex_src2_sel_r <= bus.id_src2_sel;
         ex_alu_func_r <= bus.id_alu_func;
         ex_we_r       <= bus.id_we;
         ex_mem_read_r <= bus.id_mem_read;
      end
   end

   // Saturating count of inserted load-use bubbles.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.alu_src1    = alu_src1_s;
   assign bus.alu_src2    = alu_src2_s;
   assign bus.alu_func    = ex_alu_func_r;
   assign bus.ex_valid    = ex_valid_r;
   assign bus.ex_we       = ex_we_s;
   assign bus.ex_mem_read = ex_mem_read_s;
   assign bus.ex_rd       = ex_rd_r;
   assign bus.ex_rs2_fwd  = fwd_rs2_s;
   assign bus.stall_ifid  = stall_s;
   assign bus.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_ex_operand_stage;

   logic clk = 1'b0;
   logic rstn;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ex_operand_stage_if #(.XLEN(32), .STALL_CNT_W(16)) bus ();
   ex_operand_stage_if #(.XLEN(32), .STALL_CNT_W(2))  bus_sat ();

   ex_operand_stage #(.XLEN(32), .STALL_CNT_W(16)) dut     (.clk(clk), .rstn(rstn), .bus(bus));
   ex_operand_stage #(.XLEN(32), .STALL_CNT_W(2))  dut_sat (.clk(clk), .rstn(rstn), .bus(bus_sat));

   // The narrow-counter instance sees exactly the same stimulus.
   assign bus_sat.id_valid    = bus.id_valid;
   assign bus_sat.id_pc       = bus.id_pc;
   assign bus_sat.id_imm      = bus.id_imm;
   assign bus_sat.id_rs1_data = bus.id_rs1_data;
   assign bus_sat.id_rs2_data = bus.id_rs2_data;
   assign bus_sat.id_rs1      = bus.id_rs1;
   assign bus_sat.id_rs2      = bus.id_rs2;
   assign bus_sat.id_rd       = bus.id_rd;
   assign bus_sat.id_use_rs1  = bus.id_use_rs1;
   assign bus_sat.id_use_rs2  = bus.id_use_rs2;
   assign bus_sat.id_src1_sel = bus.id_src1_sel;
   assign bus_sat.id_src2_sel = bus.id_src2_sel;
   assign bus_sat.id_alu_func = bus.id_alu_func;
   assign bus_sat.id_we       = bus.id_we;
   assign bus_sat.id_mem_read = bus.id_mem_read;
   assign bus_sat.flush       = bus.flush;
   assign bus_sat.mem_valid   = bus.mem_valid;
   assign bus_sat.mem_we      = bus.mem_we;
   assign bus_sat.mem_rd      = bus.mem_rd;
   assign bus_sat.mem_result  = bus.mem_result;
   assign bus_sat.wb_valid    = bus.wb_valid;
   assign bus_sat.wb_we       = bus.wb_we;
   assign bus_sat.wb_rd       = bus.wb_rd;
   assign bus_sat.wb_data     = bus.wb_data;

   // Reference model: the instruction currently sitting in EX plus bubble counters.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        src1_sel;
      logic        src2_sel;
      logic [3:0]  func;
      logic        we;
      logic        mem_read;
   } instr_t;

   instr_t m = '0;
   int     m_cnt = 0;
   int     m_cnt_sat = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_operand(input logic [4:0] r, input logic [31:0] rf);
      if (r == 5'd0) return 32'd0;
      if (bus.mem_valid && bus.mem_we && bus.mem_rd == r) return bus.mem_result;
      if (bus.wb_valid && bus.wb_we && bus.wb_rd == r) return bus.wb_data;
      return rf;
   endfunction

   function automatic logic model_stall();
      logic reads_load;
      reads_load = (bus.id_use_rs1 && bus.id_rs1 == m.rd) || (bus.id_use_rs2 && bus.id_rs2 == m.rd);
      return m.valid && m.mem_read && m.rd != 5'd0 && bus.id_valid && !bus.flush && reads_load;
   endfunction

   task automatic check_model();
      logic [31:0] op1;
      logic [31:0] op2;
      op1 = model_operand(m.rs1, m.rs1_data);
      op2 = model_operand(m.rs2, m.rs2_data);
      check_eq("ex_valid", bus.ex_valid, m.valid);
      check_eq("ex_we", bus.ex_we, m.valid & m.we);
      check_eq("ex_mem_read", bus.ex_mem_read, m.valid & m.mem_read);
      check_eq("stall_ifid", bus.stall_ifid, model_stall());
      check_eq("stall_cnt", bus.stall_cnt, m_cnt);
      check_eq("stall_cnt_sat", bus_sat.stall_cnt, m_cnt_sat);
      if (m.valid) begin
         check_eq("alu_src1", bus.alu_src1, m.src1_sel ? m.pc : op1);
         check_eq("alu_src2", bus.alu_src2, m.src2_sel ? m.imm : op2);
         check_eq("alu_func", bus.alu_func, m.func);
         check_eq("ex_rd", bus.ex_rd, m.rd);
         check_eq("ex_rs2_fwd", bus.ex_rs2_fwd, op2);
      end
   endtask

   task automatic model_update();
      logic hz;
      hz = model_stall();
      if (!rstn) begin
         m         = '0;
         m_cnt     = 0;
         m_cnt_sat = 0;
      end else if (bus.flush) begin
         m.valid = 1'b0;
      end else if (hz) begin
         m.valid = 1'b0;
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_sat < 3) m_cnt_sat++;
      end else begin
         m.valid    = bus.id_valid;
         m.pc       = bus.id_pc;
         m.imm      = bus.id_imm;
         m.rs1_data = bus.id_rs1_data;
         m.rs2_data = bus.id_rs2_data;
         m.rs1      = bus.id_rs1;
         m.rs2      = bus.id_rs2;
         m.rd       = bus.id_rd;
         m.src1_sel = bus.id_src1_sel;
         m.src2_sel = bus.id_src2_sel;
         m.func     = bus.id_alu_func;
         m.we       = bus.id_we;
         m.mem_read = bus.id_mem_read;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_valid = 1'b0;    bus.id_pc = 32'd0;       bus.id_imm = 32'd0;
      bus.id_rs1_data = 32'd0; bus.id_rs2_data = 32'd0;
      bus.id_rs1 = 5'd0;      bus.id_rs2 = 5'd0;       bus.id_rd = 5'd0;
      bus.id_use_rs1 = 1'b0;  bus.id_use_rs2 = 1'b0;
      bus.id_src1_sel = 1'b0; bus.id_src2_sel = 1'b0;  bus.id_alu_func = 4'd0;
      bus.id_we = 1'b0;       bus.id_mem_read = 1'b0;  bus.flush = 1'b0;
      bus.mem_valid = 1'b0;   bus.mem_we = 1'b0;       bus.mem_rd = 5'd0; bus.mem_result = 32'd0;
      bus.wb_valid = 1'b0;    bus.wb_we = 1'b0;        bus.wb_rd = 5'd0;  bus.wb_data = 32'd0;
   endtask

   task automatic present_load(input logic [4:0] rd);
      clear_inputs();
      bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_we = 1'b1; bus.id_rd = rd;
      bus.id_rs1 = 5'd1; bus.id_use_rs1 = 1'b1; bus.id_src2_sel = 1'b1; bus.id_imm = 32'h8;
   endtask

   task automatic present_add_dep(input logic [4:0] rs1);
      clear_inputs();
      bus.id_valid = 1'b1; bus.id_we = 1'b1; bus.id_rd = 5'd6;
      bus.id_rs1 = rs1;    bus.id_use_rs1 = 1'b1;
      bus.id_rs2 = 5'd2;   bus.id_use_rs2 = 1'b1; bus.id_rs2_data = 32'h5;
   endtask

   initial begin
      clear_inputs();
      rstn = 1'b0;
      bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_data = 32'hFFFF; bus.id_rd = 5'd9;
      repeat (2) begin
         @(posedge clk);
         model_update();
         #1;
      end
      check_eq("rst_ex_valid", bus.ex_valid, 1'b0);
      check_eq("rst_alu_src1", bus.alu_src1, 32'd0);
      check_eq("rst_alu_src2", bus.alu_src2, 32'd0);
      check_eq("rst_stall_cnt", bus.stall_cnt, 16'd0);
      check_eq("rst_stall_ifid", bus.stall_ifid, 1'b0);

      // addi x5, x1, 7
      rstn = 1'b1;
      clear_inputs();
      bus.id_valid = 1'b1; bus.id_rs1 = 5'd1; bus.id_rs1_data = 32'h10; bus.id_use_rs1 = 1'b1;
      bus.id_imm = 32'h7;  bus.id_src2_sel = 1'b1; bus.id_rd = 5'd5; bus.id_we = 1'b1;
      tick();
      clear_inputs();
      #1;
      check_eq("issue_src1", bus.alu_src1, 32'h10);
      check_eq("issue_src2", bus.alu_src2, 32'h7);
      check_eq("issue_func", bus.alu_func, 4'd0);
      check_eq("issue_rd", bus.ex_rd, 5'd5);

      // forwarding priority on x3
      bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_data = 32'h1; bus.id_use_rs1 = 1'b1;
      bus.id_rd = 5'd7; bus.id_we = 1'b1;
      tick();
      clear_inputs();
      bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_rd = 5'd3; bus.mem_result = 32'hAA;
      bus.wb_valid = 1'b1;  bus.wb_we = 1'b1;  bus.wb_rd = 5'd3;  bus.wb_data = 32'hBB;
      #1;
      check_eq("fwd_mem_prio", bus.alu_src1, 32'hAA);
      bus.mem_we = 1'b0;
      #1;
      check_eq("fwd_wb", bus.alu_src1, 32'hBB);
      bus.mem_we = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
      #1;
      check_eq("fwd_none", bus.alu_src1, 32'h1);
      bus.id_valid = 1'b1; bus.id_rs1 = 5'd0; bus.id_rs1_data = 32'h55; bus.id_use_rs1 = 1'b1;
      tick();
      bus.id_valid = 1'b0;
      #1;
      check_eq("fwd_x0", bus.alu_src1, 32'd0);

      // load-use: lw x4 in EX, add x6 = x4 + x2 in ID
      present_load(5'd4);
      tick();
      present_add_dep(5'd4);
      #1;
      check_eq("lu_stall", bus.stall_ifid, 1'b1);
      tick();
      bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_rd = 5'd4; bus.mem_result = 32'hDEAD;
      #1;
      check_eq("lu_bubble", bus.ex_valid, 1'b0);
      check_eq("lu_stall_once", bus.stall_ifid, 1'b0);
      check_eq("lu_cnt", bus.stall_cnt, 16'd1);
      tick();
      clear_inputs();
      bus.wb_valid = 1'b1; bus.wb_we = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h1234;
      #1;
      check_eq("lu_issue", bus.ex_valid, 1'b1);
      check_eq("lu_src1_wb", bus.alu_src1, 32'h1234);
      check_eq("lu_rs2", bus.ex_rs2_fwd, 32'h5);

      // flush beats the hazard
      present_load(5'd4);
      tick();
      present_add_dep(5'd4);
      bus.flush = 1'b1;
      #1;
      check_eq("fl_stall", bus.stall_ifid, 1'b0);
      tick();
      clear_inputs();
      #1;
      check_eq("fl_bubble", bus.ex_valid, 1'b0);
      check_eq("fl_cnt", bus.stall_cnt, 16'd1);

      // five more hazards: the 2-bit counter pins at 3
      for (int k = 0; k < 5; k++) begin
         present_load(5'd4);
         tick();
         present_add_dep(5'd4);
         #1;
         check_eq("sat_stall", bus.stall_ifid, 1'b1);
         tick();
      end
      clear_inputs();
      #1;
      check_eq("sat_cnt", bus_sat.stall_cnt, 2'd3);
      check_eq("wide_cnt", bus.stall_cnt, 16'd6);
      tick();
      tick();
      check_eq("sat_hold", bus_sat.stall_cnt, 2'd3);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rstn             = ($urandom_range(0, 49) != 0);
         bus.id_valid     = ($urandom_range(0, 3) != 0);
         bus.id_pc        = $urandom;
         bus.id_imm       = $urandom;
         bus.id_rs1_data  = $urandom;
         bus.id_rs2_data  = $urandom;
         bus.id_rs1       = 5'($urandom_range(0, 7));
         bus.id_rs2       = 5'($urandom_range(0, 7));
         bus.id_rd        = 5'($urandom_range(0, 7));
         bus.id_use_rs1   = 1'($urandom_range(0, 1));
         bus.id_use_rs2   = 1'($urandom_range(0, 1));
         bus.id_src1_sel  = 1'($urandom_range(0, 1));
         bus.id_src2_sel  = 1'($urandom_range(0, 1));
         bus.id_alu_func  = 4'($urandom_range(0, 9));
         bus.id_we        = 1'($urandom_range(0, 1));
         bus.id_mem_read  = ($urandom_range(0, 2) == 0);
         bus.flush        = ($urandom_range(0, 7) == 0);
         bus.mem_valid    = 1'($urandom_range(0, 1));
         bus.mem_we       = 1'($urandom_range(0, 1));
         bus.mem_rd       = 5'($urandom_range(0, 7));
         bus.mem_result   = $urandom;
         bus.wb_valid     = 1'($urandom_range(0, 1));
         bus.wb_we        = 1'($urandom_range(0, 1));
         bus.wb_rd        = 5'($urandom_range(0, 7));
         bus.wb_data      = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
